// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arith_pkg
// Description : Shared types and constants for the sequential arithmetic
//               blocks. Provides the serial subtractor state encoding and
//               the default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

  localparam int SUB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage : arith_pkg
`default_nettype wire

// File: rtl/full_subtractor_bit.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor_bit
// Description : One-bit full subtractor, computes a - b - bin.
// Ports       : a    in  1  minuend bit
//               b    in  1  subtrahend bit
//               bin  in  1  borrow in
//               d    out 1  difference bit
//               bout out 1  borrow out
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when a == b and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor_bit
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial unsigned subtractor, diff = a - b mod 2^WIDTH,
//               one bit per clock LSB first, framed by start/busy/done.
// Ports       : clk        in  1      clock, rising edge
//               rst        in  1      asynchronous active-high reset
//               start      in  1      request, sampled only in IDLE
//               a          in  WIDTH  minuend, captured on accepted start
//               b          in  WIDTH  subtrahend, captured on accepted start
//               busy       out 1      high while shifting
//               done       out 1      one-cycle result-valid pulse
//               diff       out WIDTH  result (partial while busy)
//               borrow_out out 1      final borrow, 1 means a < b
//               ovf        out 1      signed overflow (SERIAL_SUB_OVF_EN only)
// Options     : define SERIAL_SUB_OVF_EN to add the ovf output.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic             borrow_out_q, borrow_out_d;
  logic             ovf_q, ovf_d;

  logic             w_slice_d;
  logic             w_slice_bout;

  full_subtractor_bit u_slice (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (w_slice_d),
    .bout (w_slice_bout)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_d        = res_q;
    borrow_d     = borrow_q;
    borrow_out_d = borrow_out_q;
    ovf_d        = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        res_d    = {w_slice_d, res_q[WIDTH-1:1]};
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        borrow_d = w_slice_bout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d      = DONE;
          borrow_out_d = w_slice_bout;
          // On the last slice the operand LSBs are the original MSBs and
          // the slice output is the result MSB.
          ovf_d        = (a_sh_q[0] ^ b_sh_q[0]) & (a_sh_q[0] ^ w_slice_d);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_q        <= res_d;
      borrow_q     <= borrow_d;
      borrow_out_q <= borrow_out_d;
      ovf_q        <= ovf_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign diff       = res_q;
  assign borrow_out = borrow_out_q;

`ifdef SERIAL_SUB_OVF_EN
  assign ovf = ovf_q;
`else
  logic w_ovf_unused;
  assign w_ovf_unused = ovf_q;
`endif

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed self-checking bench for serial_subtractor, WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int vectors    = 0;
  int miscompares = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation: start accepted at the next edge, done expected on
  // the ninth falling edge after it.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [7:0] ed, input logic eb, input logic eo);
    int n;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v;
    @(negedge clk);
    start = 1'b0; n = 1;
    check("busy_after_start", 32'(busy), 32'd1);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'd9);
    check("diff", 32'(diff), 32'(ed));
    check("borrow_out", 32'(borrow_out), 32'(eb));
    check("busy_in_done", 32'(busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: unexpected x");
`endif
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("diff_hold", 32'(diff), 32'(ed));
  endtask

  initial begin
    int dones;
    int last_done;
    int first_gap;

    // Reset state
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    rst = 1'b0;

    // Directed operations
    run_op(8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
    run_op(8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run_op(8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op(8'h01, 8'h80, 8'h81, 1'b1, 1'b1);

    // Start pulses in RUN and DONE must be ignored
    @(negedge clk);
    start = 1'b1; a = 8'h35; b = 8'h12;
    dones = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        check("ignore_done_cycle", 32'(n), 32'd9);
        check("ignore_diff", 32'(diff), 32'h23);
        check("ignore_borrow", 32'(borrow_out), 32'd0);
      end
      if (n >= 10) check("ignore_idle_busy", 32'(busy), 32'd0);
      start = (n == 3 || n == 9);
      a = 8'hFF; b = 8'h00;
    end
    start = 1'b0;
    check("ignore_done_count", 32'(dones), 32'd1);

    // Reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; a = 8'h35; b = 8'h12;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_borrow", 32'(borrow_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);
    run_op(8'h35, 8'h12, 8'h23, 1'b0, 1'b0);

    // Back-to-back with start held high
    @(negedge clk);
    start = 1'b1; a = 8'h35; b = 8'h12;
    dones = 0; last_done = 0; first_gap = 0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        check("b2b_diff", 32'(diff), 32'h23);
        if (dones == 1) check("b2b_first", 32'(n), 32'd9);
        else check("b2b_gap", 32'(n - last_done), 32'(WIDTH + 2));
        last_done = n;
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(dones), 32'd4);
    if (first_gap != 0) $display("note: unused gap %0d", first_gap);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_serial_subtractor
`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor: computes `a - b` for two WIDTH-bit operands, one bit per clock, LSB first. A borrow flip-flop carries between bit slices, and a start/busy/done handshake frames each operation. It sits alongside the combinational adder blocks in the arithmetic library as the low-area, sequential subtract path. Each bit slice is a full subtractor.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width, in bits (≥2).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; captured on an accepted start.
- `b`  in  WIDTH  subtrahend; captured on an accepted start.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; result is valid.
- `diff`  out  WIDTH  result `a - b` modulo 2^WIDTH.
- `borrow_out`  out  1  final borrow; 1 means `a < b` (unsigned).

## Operation
- FSM states:
  - IDLE: waits for start.
  - RUN: shifts WIDTH bits.
  - DONE: pulses `done` for one cycle.
- IDLE → RUN when `start`=1. On that edge:
  - `a` and `b` load into shift registers.
  - The borrow flop clears to 0.
  - The bit counter clears to 0.
- RUN, each cycle:
  - Bit slice: `d = a0 ^ b0 ^ bin`; `bout = (~a0 & b0) | (~(a0 ^ b0) & bin)`.
  - `d` shifts into the MSB of the result register, which shifts right.
  - The operand registers shift right.
  - The borrow flop takes `bout`.
  - The counter increments.
- RUN → DONE on the edge that processes bit WIDTH-1.
  - `diff` then holds the full result.
  - `borrow_out` takes the final `bout`.
- DONE → IDLE unconditionally after one cycle.
- `start` is ignored in RUN and in DONE. No queuing; the captured operands are unaffected.
- `diff` and `borrow_out` hold their value from DONE until the next accepted start. They are undefined-free, but not guaranteed during RUN: the partial result is visible.
- Counter width is `$clog2(WIDTH)`; it must not wrap before reaching WIDTH-1.

Reset:
- Async assert forces IDLE and clears all registers.
- Reset values: `busy`=0, `done`=0, `diff`=0, `borrow_out`=0.
- Reset mid-RUN abandons the operation; no `done` is issued.
- Deassertion is synchronized externally.

## Timing
- Start accepted at edge k.
- `busy`=1 from after edge k through edge k+WIDTH.
- `done`=1 for exactly the cycle after edge k+WIDTH. `diff` and `borrow_out` are valid in that cycle.
- Earliest next accepted start: edge k+WIDTH+2.
- Start-to-done latency: WIDTH+1 cycles. Throughput: one result per WIDTH+2 cycles.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `SERIAL_SUB_OVF_EN`.
  - Defined: adds output port `ovf` (1 bit, reset 0). It is the signed two's-complement overflow, `(a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB])`. It is registered with `diff` in DONE and held identically.
  - Undefined: the port and its logic are absent; all other behaviour is unchanged.

## Structure
- Package `arith_pkg`:
  - State enum `sub_state_t` {IDLE, RUN, DONE}.
  - Default width constant.
- Sub-module `full_subtractor_bit`: combinational `a`, `b`, `bin` → `d`, `bout`. It is instantiated once in the datapath.
- Top level: FSM, counter, operand and result shift registers, borrow flop.

## Test plan
- WIDTH=8, a=0x35, b=0x12 → after 9 cycles `done`, `diff`=0x23, `borrow_out`=0.
- a=0x12, b=0x35 → `diff`=0xDD, `borrow_out`=1. Also a=0x00, b=0x01 → `diff`=0xFF, `borrow_out`=1.
- a=0xAA, b=0xAA → `diff`=0x00, `borrow_out`=0. With the macro defined, a=0x80, b=0x01 → `diff`=0x7F, `ovf`=1.
- Start a=0x35, b=0x12. Pulse `start` with a=0xFF, b=0x00 at RUN cycles 3 and in DONE. Expect a single `done` with 0x23, then IDLE.
- Assert `rst` at RUN cycle 4. Expect all outputs 0, no `done`, and a fresh start completing normally.
- Back-to-back: start held high continuously. Expect `done` pulses exactly WIDTH+2 cycles apart.
